// File: rtl/rb_alu_seq.sv
// rb_alu_seq: arbitrates the register-bank write port and the 32-bit ALU between
// an ALU-instruction channel and an immediate-load channel. Optional macro: R0_ZERO_EN.
module rb_alu_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [OP_W-1:0]   ins_op,
    input  logic [ADDR_W-1:0] ins_rd,
    input  logic [ADDR_W-1:0] ins_rs1,
    input  logic [ADDR_W-1:0] ins_rs2,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] rb_rs1_addr,
    output logic [ADDR_W-1:0] rb_rs2_addr,
    output logic [ADDR_W-1:0] rb_rd_addr,
    output logic [DATA_W-1:0] rb_wdata,
    output logic              rb_we,
    input  logic [DATA_W-1:0] rb_rs1_data,
    input  logic [DATA_W-1:0] rb_rs2_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_y,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] last_result
);

`ifdef R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EX   = 3'd2,
        ST_WB   = 3'd3,
        ST_LD   = 3'd4
    } state_t;

    state_t            state_r;
    logic              prio_ins_r;
    logic [OP_W-1:0]   op_r;
    logic [ADDR_W-1:0] rd_r;
    logic [ADDR_W-1:0] rs1_r;
    logic [ADDR_W-1:0] rs2_r;
    logic [ADDR_W-1:0] ld_addr_r;
    logic [DATA_W-1:0] ld_data_r;
    logic [DATA_W-1:0] opa_r;
    logic [DATA_W-1:0] opb_r;
    logic [DATA_W-1:0] res_r;
    logic [ADDR_W-1:0] rb_rd_addr_r;
    logic [DATA_W-1:0] rb_wdata_r;
    logic              rb_we_r;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] last_result_r;
    logic              ins_grant_s;
    logic              ld_grant_s;
    logic              conflict_s;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return R0_ZERO && (addr == {ADDR_W{1'b0}});
    endfunction

    // Bank data as seen by the datapath (register 0 may read as constant zero).
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
        return is_zero_reg(addr) ? {DATA_W{1'b0}} : data;
    endfunction

    // Grant arbitration: only in IDLE, alternating when both channels request.
    always_comb begin
        ins_grant_s = 1'b0;
        ld_grant_s  = 1'b0;
        conflict_s  = ins_valid & ld_valid;
        if (state_r == ST_IDLE) begin
            ins_grant_s = ins_valid & (~ld_valid | prio_ins_r);
            ld_grant_s  = ld_valid & (~ins_valid | ~prio_ins_r);
        end else begin
            ins_grant_s = 1'b0;
            ld_grant_s  = 1'b0;
        end
    end

    // Sequencer FSM with registered Moore outputs.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            prio_ins_r    <= 1'b0;
            op_r          <= {OP_W{1'b0}};
            rd_r          <= {ADDR_W{1'b0}};
            rs1_r         <= {ADDR_W{1'b0}};
            rs2_r         <= {ADDR_W{1'b0}};
            ld_addr_r     <= {ADDR_W{1'b0}};
            ld_data_r     <= {DATA_W{1'b0}};
            opa_r         <= {DATA_W{1'b0}};
            opb_r         <= {DATA_W{1'b0}};
            res_r         <= {DATA_W{1'b0}};
            rb_rd_addr_r  <= {ADDR_W{1'b0}};
            rb_wdata_r    <= {DATA_W{1'b0}};
            rb_we_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            last_result_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rb_we_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (ins_grant_s) begin
                        op_r    <= ins_op;
                        rd_r    <= ins_rd;
                        rs1_r   <= ins_rs1;
                        rs2_r   <= ins_rs2;
                        busy_r  <= 1'b1;
                        state_r <= ST_RD;
                        if (conflict_s) begin
                            prio_ins_r <= ~prio_ins_r;
                        end
                    end else if (ld_grant_s) begin
                        ld_addr_r    <= ld_addr;
                        ld_data_r    <= ld_data;
                        rb_rd_addr_r <= ld_addr;
                        rb_wdata_r   <= ld_data;
                        rb_we_r      <= ~is_zero_reg(ld_addr);
                        done_r       <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_LD;
                        if (conflict_s) begin
                            prio_ins_r <= ~prio_ins_r;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    opa_r   <= read_val(rs1_r, rb_rs1_data);
                    opb_r   <= read_val(rs2_r, rb_rs2_data);
                    state_r <= ST_EX;
                end
                ST_EX: begin
                    // Write fields are loaded here so they are stable for the whole WB cycle.
                    res_r        <= alu_y;
                    rb_rd_addr_r <= rd_r;
                    rb_wdata_r   <= alu_y;
                    rb_we_r      <= ~is_zero_reg(rd_r);
                    done_r       <= 1'b1;
                    state_r      <= ST_WB;
                end
                ST_WB: begin
                    last_result_r <= read_val(rd_r, res_r);
                    rb_we_r       <= 1'b0;
                    done_r        <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                ST_LD: begin
                    last_result_r <= read_val(ld_addr_r, ld_data_r);
                    rb_we_r       <= 1'b0;
                    done_r        <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    rb_we_r <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ins_ready   = ins_grant_s;
    assign ld_ready    = ld_grant_s;
    assign rb_rs1_addr = rs1_r;
    assign rb_rs2_addr = rs2_r;
    assign rb_rd_addr  = rb_rd_addr_r;
    assign rb_wdata    = rb_wdata_r;
    assign rb_we       = rb_we_r;
    assign alu_a       = opa_r;
    assign alu_b       = opb_r;
    assign alu_op      = op_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign last_result = last_result_r;

endmodule

// File: tb/tb_rb_alu_seq.sv
// Bench for rb_alu_seq: behavioural register bank and ALU around the DUT,
// table-driven requests with a scoreboard of expected writes.
module tb_rb_alu_seq;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
`ifdef R0_ZERO_EN
    localparam logic R0Z = 1'b1;
`else
    localparam logic R0Z = 1'b0;
`endif

    logic          CLK;
    logic          rst;
    logic          ins_valid, ins_ready, ld_valid, ld_ready;
    logic [OW-1:0] ins_op;
    logic [AW-1:0] ins_rd, ins_rs1, ins_rs2, ld_addr;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] rb_rs1_addr, rb_rs2_addr, rb_rd_addr;
    logic [DW-1:0] rb_wdata, rb_rs1_data, rb_rs2_data;
    logic          rb_we, busy, done;
    logic [DW-1:0] alu_a, alu_b, alu_y, last_result;
    logic [OW-1:0] alu_op;

    logic [DW-1:0] bank [0:15] = '{default: 32'd0};
    logic [DW-1:0] shadow [0:15] = '{default: 32'd0};
    int cyc = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        we;
        int          cyc;
        logic [31:0] lr;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        is_ld;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [14];

    int          checks = 0;
    int          failures = 0;
    logic        lr_pend = 1'b0;
    logic [31:0] lr_exp = 32'd0;

    rb_alu_seq #(.ADDR_W(AW), .DATA_W(DW), .OP_W(OW)) dut (
        .CLK(CLK), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
        .ins_rd(ins_rd), .ins_rs1(ins_rs1), .ins_rs2(ins_rs2),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rb_rs1_addr(rb_rs1_addr), .rb_rs2_addr(rb_rs2_addr), .rb_rd_addr(rb_rd_addr),
        .rb_wdata(rb_wdata), .rb_we(rb_we),
        .rb_rs1_data(rb_rs1_data), .rb_rs2_data(rb_rs2_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .busy(busy), .done(done), .last_result(last_result)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always_ff @(posedge CLK) cyc <= cyc + 1;

    always_ff @(posedge CLK) begin
        if (rb_we) bank[rb_rd_addr] <= rb_wdata;
    end

    assign rb_rs1_data = bank[rb_rs1_addr];
    assign rb_rs2_data = bank[rb_rs2_addr];

    always_comb begin
        case (alu_op)
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SUB:  alu_y = alu_a - alu_b;
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_XOR:  alu_y = alu_a ^ alu_b;
            OP_SLL:  alu_y = alu_a << alu_b[4:0];
            OP_SRL:  alu_y = alu_a >> alu_b[4:0];
            default: alu_y = alu_a;
        endcase
    end

    function automatic logic [31:0] rd_sh(input logic [3:0] a);
        return (R0Z && a == 4'd0) ? 32'd0 : shadow[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (lr_pend) begin
            chk("last_result", last_result, lr_exp);
            lr_pend = 1'b0;
        end
        chk("ready_exclusive", {31'd0, ins_ready & ld_ready}, 32'd0);
        chk("we_outside_done", {31'd0, rb_we & ~done}, 32'd0);
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("done_without_request", {31'd0, done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rb_we", {31'd0, rb_we}, {31'd0, e.we});
                if (e.we) begin
                    chk("rb_rd_addr", {28'd0, rb_rd_addr}, {28'd0, e.addr});
                    chk("rb_wdata", rb_wdata, e.data);
                end
                chk("write_cycle", cyc, e.cyc);
                lr_pend = 1'b1;
                lr_exp  = e.lr;
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        monitor();
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [31:0] d, input logic we,
                            input int lat, input logic [31:0] lr);
        exp_t e;
        e.addr = a; e.data = d; e.we = we; e.cyc = cyc + 1 + lat; e.lr = lr;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic is_ld, input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2, input logic [31:0] data,
                         input logic [31:0] exp_data, input logic exp_we, input logic [31:0] exp_lr);
        logic got;
        got = 1'b0;
        if (is_ld) begin
            ld_addr = rd; ld_data = data; ld_valid = 1'b1;
        end else begin
            ins_op = op; ins_rd = rd; ins_rs1 = rs1; ins_rs2 = rs2; ins_valid = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (is_ld ? ld_ready : ins_ready) begin
                push_exp(rd, exp_data, exp_we, is_ld ? 0 : 2, exp_lr);
                if (exp_we) shadow[rd] = exp_data;
                got = 1'b1;
            end
            step();
        end
        ins_valid = 1'b0;
        ld_valid  = 1'b0;
        chk("issue_handshake", {31'd0, got}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sb_q.size() != 0 || lr_pend); i++) step();
        chk("drain_pending", sb_q.size(), 32'd0);
    endtask

    initial begin
        logic [3:0]  ord;
        int          ngrant;
        logic        gl, gi;
        logic [31:0] ev;

        vecs[0]  = '{1'b1, OP_ADD, 4'd3,  4'd0,  4'd0,  32'h0000_0005, 32'h0000_0005};
        vecs[1]  = '{1'b1, OP_ADD, 4'd4,  4'd0,  4'd0,  32'h0000_0007, 32'h0000_0007};
        vecs[2]  = '{1'b0, OP_ADD, 4'd5,  4'd3,  4'd4,  32'h0,         32'h0000_000C};
        vecs[3]  = '{1'b1, OP_ADD, 4'd1,  4'd0,  4'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, OP_ADD, 4'd1,  4'd1,  4'd1,  32'h0,         32'hFFFF_FFFE};
        vecs[5]  = '{1'b0, OP_SUB, 4'd2,  4'd1,  4'd1,  32'h0,         32'h0000_0000};
        vecs[6]  = '{1'b0, OP_XOR, 4'd7,  4'd1,  4'd5,  32'h0,         32'hFFFF_FFF2};
        vecs[7]  = '{1'b0, OP_AND, 4'd11, 4'd7,  4'd4,  32'h0,         32'h0000_0002};
        vecs[8]  = '{1'b0, OP_OR,  4'd12, 4'd3,  4'd11, 32'h0,         32'h0000_0007};
        vecs[9]  = '{1'b0, OP_SLL, 4'd13, 4'd4,  4'd3,  32'h0,         32'h0000_00E0};
        vecs[10] = '{1'b0, OP_ADD, 4'd5,  4'd5,  4'd5,  32'h0,         32'h0000_0018};
        vecs[11] = '{1'b0, OP_SRL, 4'd14, 4'd1,  4'd4,  32'h0,         32'h01FF_FFFF};
        vecs[12] = '{1'b1, OP_ADD, 4'd15, 4'd0,  4'd0,  32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[13] = '{1'b0, OP_SUB, 4'd15, 4'd3,  4'd15, 32'h0,         32'h5A5A_A5AB};

        rst = 1'b0; ins_valid = 1'b0; ld_valid = 1'b0;
        ins_op = 4'd0; ins_rd = 4'd0; ins_rs1 = 4'd0; ins_rs2 = 4'd0;
        ld_addr = 4'd0; ld_data = 32'd0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_we", {31'd0, rb_we}, 32'd0);
        chk("reset_last_result", last_result, 32'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].is_ld, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].data, vecs[i].exp, 1'b1, vecs[i].exp);
        end
        drain();

        // Phase-by-phase view of one ADD.
        issue(1'b0, OP_ADD, 4'd5, 4'd3, 4'd4, 32'd0, 32'h0000_000C, 1'b1, 32'h0000_000C);
        chk("rd_rs1_addr", {28'd0, rb_rs1_addr}, 32'd3);
        chk("rd_rs2_addr", {28'd0, rb_rs2_addr}, 32'd4);
        chk("rd_busy", {31'd0, busy}, 32'd1);
        step();
        chk("ex_alu_a", alu_a, 32'd5);
        chk("ex_alu_b", alu_b, 32'd7);
        chk("ex_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
        chk("ex_busy", {31'd0, busy}, 32'd1);
        step();
        chk("wb_busy", {31'd0, busy}, 32'd1);
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        drain();

        // Reset during WB aborts the write.
        ins_op = OP_ADD; ins_rd = 4'd10; ins_rs1 = 4'd3; ins_rs2 = 4'd4; ins_valid = 1'b1;
        #1 chk("abort_ins_ready", {31'd0, ins_ready}, 32'd1);
        @(negedge CLK) ins_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_wb_we", {31'd0, rb_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_we_cleared", {31'd0, rb_we}, 32'd0);
        chk("abort_done_cleared", {31'd0, done}, 32'd0);
        chk("abort_busy_cleared", {31'd0, busy}, 32'd0);
        @(negedge CLK) rst = 1'b1;
        repeat (4) step();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_last_result", last_result, 32'd0);
        chk("abort_no_write", bank[10], 32'd0);

        // Both channels requesting: grants must alternate starting with the load.
        ld_addr = 4'd8; ld_data = 32'h0000_0100;
        ins_op = OP_ADD; ins_rd = 4'd9; ins_rs1 = 4'd8; ins_rs2 = 4'd8;
        ins_valid = 1'b1; ld_valid = 1'b1;
        ngrant = 0; ord = 4'd0;
        for (int i = 0; i < 60 && ngrant < 4; i++) begin
            #1;
            gl = ld_ready;
            gi = ins_ready;
            if (gl) begin
                push_exp(4'd8, ld_data, 1'b1, 0, ld_data);
                shadow[8] = ld_data;
            end else if (gi) begin
                ev = rd_sh(4'd8) + rd_sh(4'd8);
                push_exp(4'd9, ev, 1'b1, 2, ev);
                shadow[9] = ev;
            end
            if (gl || gi) begin
                ord = {ord[2:0], gi};
                ngrant++;
            end
            step();
            if (gl) ld_data = ld_data + 32'd1;
        end
        ins_valid = 1'b0; ld_valid = 1'b0;
        chk("grant_count", ngrant, 32'd4);
        chk("grant_order", {28'd0, ord}, 32'h0000_0005);
        drain();

        // Register 0 behaviour.
        issue(1'b1, OP_ADD, 4'd0, 4'd0, 4'd0, 32'h0000_1234, 32'h0000_1234,
              ~R0Z, R0Z ? 32'd0 : 32'h0000_1234);
        drain();
        ev = R0Z ? 32'd0 : 32'h0000_2468;
        issue(1'b0, OP_ADD, 4'd6, 4'd0, 4'd0, 32'd0, ev, 1'b1, ev);
        drain();
        chk("r6_bank", bank[6], ev);
        chk("r0_bank", bank[0], R0Z ? 32'd0 : 32'h0000_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rb_alu_seq.md
Name: rb_alu_seq

Overview:
- Sequencer that shares the register bank write port and the 32-bit ALU between two requesters: an ALU-instruction channel and an immediate-load channel.
- Each ALU instruction runs in four phases: read operands, execute, write back, then return to idle.
- Sits between the switch/host front end and REG_BANK/K_ALU_32. It owns every register bank address and the write-enable; the display path still reads through the bank's separate out port.

Parameters:
ADDR_W, 4, register bank address width (16 registers)
DATA_W, 32, datapath width
OP_W, 4, ALU opcode width

Ports:
CLK  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
ins_valid  in  1  ALU instruction request
ins_ready  out  1  instruction accepted this cycle when high with ins_valid
ins_op  in  OP_W  ALU opcode
ins_rd  in  ADDR_W  destination register
ins_rs1  in  ADDR_W  source register 1
ins_rs2  in  ADDR_W  source register 2
ld_valid  in  1  immediate load request
ld_ready  out  1  load accepted this cycle when high with ld_valid
ld_addr  in  ADDR_W  load destination register
ld_data  in  DATA_W  load value
rb_rs1_addr  out  ADDR_W  bank read address 1
rb_rs2_addr  out  ADDR_W  bank read address 2
rb_rd_addr  out  ADDR_W  bank write address
rb_wdata  out  DATA_W  bank write data
rb_we  out  1  bank write enable
rb_rs1_data  in  DATA_W  bank read data 1 (combinational from address)
rb_rs2_data  in  DATA_W  bank read data 2
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_op  out  OP_W  ALU opcode
alu_y  in  DATA_W  ALU result (combinational)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when a write retires
last_result  out  DATA_W  value of the most recent retired write

Behaviour:
- Reset: rst low asynchronously forces state=IDLE.
  - All registered values reset to 0: rb_we, done, busy, last_result, latched op/addresses/operands.
  - prio_ins=0, so loads win the first conflict.
  - Reset mid-operation aborts the operation; no write occurs.
- States: IDLE, RD, EX, WB, LD.
- IDLE:
  - Grant rule: ins_ready = idle & ins_valid & (!ld_valid | prio_ins). ld_ready = idle & ld_valid & (!ins_valid | !prio_ins).
  - At most one ready is high per cycle.
  - Instruction handshake: latch op/rd/rs1/rs2, go to RD.
  - Load handshake: latch addr/data, go to LD.
  - When both are valid, the grant alternates: prio_ins toggles after each conflicted grant only.
- RD: drive rb_rs1_addr/rb_rs2_addr from the latched rs1/rs2. Register rb_rs1_data/rb_rs2_data into opA/opB. Go to EX.
- EX:
  - alu_a=opA, alu_b=opB, alu_op=latched op.
  - Register alu_y into res. Go to WB.
- WB:
  - rb_we=1, rb_rd_addr=rd, rb_wdata=res.
  - done=1; last_result<=res. Go to IDLE.
- LD:
  - rb_we=1, rb_rd_addr=ld_addr, rb_wdata=ld_data.
  - done=1; last_result<=ld_data. Go to IDLE.
- Latency: ALU instruction handshake at edge T gives rb_we/done high in cycle T+3. Load handshake at T gives the write in cycle T+1.
- Throughput: at most one request accepted per IDLE cycle. The IDLE cycle after every write guarantees read-after-write correctness; no forwarding.
- rb_we, done and the rb_* write fields are Moore outputs of state. rb_rs*_addr and alu_* hold their latched values outside their active state.
- rd==rs1==rs2 is legal: the old value is read and the new value written.
- Request inputs are ignored while busy; requesters hold valid until ready.

Optional Feature:
- Macro R0_ZERO_EN.
- Defined: register 0 is constant zero.
  - Writes with destination 0 still sequence and pulse done, but rb_we stays 0 and last_result is set to 0.
  - Reads of address 0 substitute 0 for the bank data.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then idle: rst=0 mid-WB -> rb_we=0 immediately; after release busy=0, last_result=0, no write seen.
- Load: ld addr=3 data=0x0000_0005, ld addr=4 data=0x0000_0007 -> rb_we at T+1 each, done pulses, last_result=7.
- ALU op: ins op=ADD, rd=5, rs1=3, rs2=4 -> rs1/rs2 addresses 3/4 in RD, alu_a=5/alu_b=7 in EX, write 0x0000_000C to r5 at T+3, busy high 3 cycles.
- Conflict arbitration: ins_valid and ld_valid held high across 4 grants -> grant order LD, INS, LD, INS; never both ready in one cycle.
- Back-to-back dependency: load r1=0xFFFF_FFFF, then ADD r1=r1+r1 -> r1=0xFFFF_FFFE (wrap); next SUB r2=r1-r1 reads the updated r1 -> 0.
- R0_ZERO_EN defined: load r0=0x1234 -> done pulse, rb_we=0; ADD r6=r0+r0 -> r6=0. Undefined: r0 reads back 0x1234.
